// File: rtl/instruction_fetch_register.sv
// Instruction fetch register: fetches one instruction per cycle of IDLE/REQ/EXEC into I
// and steps the decoder micro-state. Optional fetch timeout via `IFETCH_TIMEOUT_EN.
module instruction_fetch_register #(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        ns,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  output logic [31:0]       I,
  output logic [1:0]        state,
  output logic              instr_valid,
  output logic              fetch_fault
);

  typedef enum logic [1:0] {IDLE, REQ, EXEC, FAULT} fsm_t;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("instruction_fetch_register: TIMEOUT must be in 2..255");
  end

  fsm_t              r_fsm, w_fsm;
  logic              r_armed, w_armed;
  logic              r_req, w_req;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [31:0]       r_I, w_I;
  logic [1:0]        r_ustate, w_ustate;
  logic              r_valid, w_valid;

`ifdef IFETCH_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_cnt, w_cnt;
  logic       r_fault, w_fault;
`endif

  // The first IDLE after reset is held one extra cycle (r_armed) so the
  // first request rises on the second edge after reset release.
  always_comb begin
    w_fsm    = r_fsm;
    w_armed  = r_armed;
    w_req    = r_req;
    w_addr   = r_addr;
    w_I      = r_I;
    w_ustate = r_ustate;
    w_valid  = r_valid;
`ifdef IFETCH_TIMEOUT_EN
    w_cnt    = r_cnt;
    w_fault  = r_fault;
`endif
    case (r_fsm)
      IDLE: begin
        if (!r_armed) begin
          w_armed = 1'b1;
        end else begin
          w_fsm  = REQ;
          w_addr = pc;
          w_req  = 1'b1;
`ifdef IFETCH_TIMEOUT_EN
          w_cnt  = '0;
`endif
        end
      end
      REQ: begin
        if (imem_ack) begin
          w_I      = imem_data;
          w_ustate = 2'b00;
          w_valid  = 1'b1;
          w_req    = 1'b0;
          w_fsm    = EXEC;
        end else begin
`ifdef IFETCH_TIMEOUT_EN
          if (r_cnt == CNT_LAST) begin
            w_fsm   = FAULT;
            w_req   = 1'b0;
            w_valid = 1'b0;
            w_fault = 1'b1;
          end else begin
            w_cnt = r_cnt + 8'd1;
          end
`endif
        end
      end
      EXEC: begin
        w_ustate = ns;
        if (ns == 2'b00) begin
          w_valid = 1'b0;
          w_fsm   = IDLE;
        end
      end
      default: begin
        w_req   = 1'b0;
        w_valid = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
        w_fault = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm    <= IDLE;
      r_armed  <= 1'b0;
      r_req    <= 1'b0;
      r_addr   <= '0;
      r_I      <= '0;
      r_ustate <= 2'b00;
      r_valid  <= 1'b0;
    end else begin
      r_fsm    <= w_fsm;
      r_armed  <= w_armed;
      r_req    <= w_req;
      r_addr   <= w_addr;
      r_I      <= w_I;
      r_ustate <= w_ustate;
      r_valid  <= w_valid;
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_cnt   <= w_cnt;
      r_fault <= w_fault;
    end
  end

  assign fetch_fault = r_fault;
`else
  assign fetch_fault = 1'b0;
`endif

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign I           = r_I;
  assign state       = r_ustate;
  assign instr_valid = r_valid;

endmodule
